// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder emulator: FSM states,
// direction constants and the phase -> {a,b} Gray table.
package enc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      TAIL
   } enc_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Phase walks 0->1->2->3 for up; adjacent phases differ in exactly one bit.
   function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
      logic [1:0] ab;
      unique case (ph)
         2'd0: ab = 2'b00;
         2'd1: ab = 2'b10;
         2'd2: ab = 2'b11;
         default: ab = 2'b01;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/quad_phase_step.sv
// Two-bit quadrature phase counter with registered {a,b} code.
// Steps one phase per advance (+1 up, -1 down); holds otherwise.
module quad_phase_step
   import enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   input  logic       dir,
   output logic [1:0] phase,
   output logic [1:0] code
);

   logic [1:0] phase_nxt;

   always_comb begin
      phase_nxt = phase;
      if (advance) begin
         phase_nxt = (dir == DIR_UP) ? phase + 2'd1 : phase - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= 2'd0;
         code  <= 2'b00;
      end else begin
         phase <= phase_nxt;
         code  <= phase_to_ab(phase_nxt);
      end
   end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder generator: N detents of A/B Gray code, one edge per STEP_DIV clocks,
// done one hold period after the last edge; start ignored while busy. ENC_BOUNCE_EN adds contact bounce.
module quad_enc_gen
   import enc_pkg::*;
#(
   parameter int STEP_DIV = 4,
   parameter int STEPS_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               dir,
   input  logic [STEPS_W-1:0] steps,
   input  logic               abort,
   output logic               a,
   output logic               b,
   output logic               busy,
   output logic               done,
   output logic [STEPS_W-1:0] steps_left
);

   localparam int DIV_W = $clog2(STEP_DIV) + 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(STEP_DIV - 1);
   // Divider phase on entry to RUN so the first edge lands STEP_DIV clocks after acceptance.
   localparam logic [DIV_W-1:0] DIV_FIRST  = DIV_W'(1 % STEP_DIV);
   localparam logic             FIRST_EDGE = (STEP_DIV == 1);

   enc_state_t       state;
   logic [DIV_W-1:0] div;
   logic             dir_q;
   logic             abort_q;
   logic             advance;
   logic             step_dir;
   logic             detent_end;
   logic [1:0]       phase;
   logic [1:0]       code;

   assign step_dir   = (state == IDLE) ? dir : dir_q;
   assign detent_end = advance && (phase == ((step_dir == DIR_UP) ? 2'd3 : 2'd1));

   always_comb begin
      advance = 1'b0;
      if (state == RUN && div == DIV_MAX) begin
         advance = 1'b1;
      end
      if (state == IDLE && start && steps != '0 && FIRST_EDGE) begin
         advance = 1'b1;
      end
   end

   quad_phase_step u_step (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .dir     (step_dir),
      .phase   (phase),
      .code    (code)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         div        <= '0;
         dir_q      <= DIR_DOWN;
         abort_q    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         steps_left <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  dir_q      <= dir;
                  steps_left <= steps;
                  abort_q    <= 1'b0;
                  if (steps == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     div   <= DIV_FIRST;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               div <= (div == DIV_MAX) ? '0 : div + 1'b1;
               if (abort) begin
                  abort_q <= 1'b1;
               end
               if (detent_end) begin
                  // Abort or last detent: drop whatever remains and go hold at rest.
                  if (abort_q || abort || steps_left <= STEPS_W'(1)) begin
                     steps_left <= '0;
                     state      <= TAIL;
                  end else begin
                     steps_left <= steps_left - 1'b1;
                  end
               end
            end
            TAIL: begin
               if (div == DIV_MAX) begin
                  div   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  div <= div + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ENC_BOUNCE_EN
   // The changing line flips back for the cycle after an edge, then settles.
   logic [1:0] prev_code;
   logic [1:0] bounce_mask;
   logic       adv_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_code   <= 2'b00;
         bounce_mask <= 2'b00;
         adv_q       <= 1'b0;
      end else begin
         adv_q <= advance;
         if (advance) begin
            prev_code <= code;
         end
         bounce_mask <= (adv_q && (STEP_DIV >= 3)) ? (code ^ prev_code) : 2'b00;
      end
   end

   assign {a, b} = code ^ bounce_mask;
`else
   assign {a, b} = code;
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// Scoreboard bench for quad_enc_gen: expected a/b, steps_left, busy and done
// change events are queued at stimulus time and matched as the DUT produces them.
module tb_quad_enc_gen;

   localparam int S  = 4;
   localparam int SW = 8;
   localparam int K_AB = 0, K_SL = 1, K_BUSY = 2, K_DONE = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, dir, abort;
   logic [SW-1:0] steps;
   logic          a, b, busy, done;
   logic [SW-1:0] steps_left;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   ev_t sbq[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;
   int  model_sl = 0;
   bit  mon_en = 1'b0;
   logic [1:0]    prev_ab = 2'b00;
   logic [SW-1:0] prev_sl = '0;
   logic          prev_busy = 1'b0;

   quad_enc_gen #(.STEP_DIV(S), .STEPS_W(SW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dir        (dir),
      .steps      (steps),
      .abort      (abort),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .steps_left (steps_left)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input int val);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.val  = val;
      sbq.push_back(e);
   endtask

   task automatic sb_match(input int kind, input string tag, input int val);
      int idx = -1;
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].kind == kind) begin
            idx = i;
            break;
         end
      end
      if (idx < 0) begin
         chk({tag, "_unexpected_at_cycle"}, cyc, -1);
      end else begin
         chk({tag, "_cycle"}, cyc, sbq[idx].cyc);
         chk({tag, "_value"}, val, sbq[idx].val);
         sbq.delete(idx);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if ({a, b} != prev_ab)     sb_match(K_AB, "ab", int'({a, b}));
         if (steps_left != prev_sl) sb_match(K_SL, "steps_left", int'(steps_left));
         if (busy != prev_busy)     sb_match(K_BUSY, "busy", int'(busy));
         if (done)                  sb_match(K_DONE, "done", 1);
      end
      prev_ab   = {a, b};
      prev_sl   = steps_left;
      prev_busy = busy;
   end

   function automatic int ab_of(input logic d, input int k);
      int r;
      case (k % 4)
         1: r = d ? 2 : 1;
         2: r = 3;
         3: r = d ? 1 : 2;
         default: r = 0;
      endcase
      return r;
   endfunction

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Called on a negedge; drives start for one cycle and queues the expected trace.
   task automatic start_seq(input logic d, input int n, input int abort_x, output int t);
      int neff, ab, ab_prev, sl;
      start = 1'b1;
      dir   = d;
      steps = SW'(n);
      t     = cyc;
      if (n == 0) begin
         if (model_sl != 0) push(K_SL, t + 1, 0);
         model_sl = 0;
         push(K_DONE, t + 1, 1);
      end else begin
         neff = n;
         if (abort_x > 0 && (abort_x + 4 * S) / (4 * S) < n) neff = (abort_x + 4 * S) / (4 * S);
         push(K_BUSY, t + 1, 1);
         if (model_sl != n) push(K_SL, t + 1, n);
         model_sl = n;
         ab_prev = 0;
         for (int k = 1; k <= 4 * neff; k++) begin
            ab = ab_of(d, k);
            push(K_AB, t + k * S, ab);
`ifdef ENC_BOUNCE_EN
            if (S >= 3) begin
               push(K_AB, t + k * S + 1, ab_prev);
               push(K_AB, t + k * S + 2, ab);
            end
`endif
            ab_prev = ab;
            if (k % 4 == 0) begin
               sl = (k / 4 == neff) ? 0 : n - k / 4;
               if (sl != model_sl) push(K_SL, t + k * S, sl);
               model_sl = sl;
            end
         end
         push(K_BUSY, t + (4 * neff + 1) * S, 0);
         push(K_DONE, t + (4 * neff + 1) * S, 1);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget = 300;
      while (sbq.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk({tag, "_pending_events"}, sbq.size(), 0);
      sbq.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; abort = 1'b0;
      #1;
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_steps_left", steps_left, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // One detent up.
      start_seq(1'b1, 1, 0, t);
      wait_cyc(t + 10);
      chk("up1_busy_mid", busy, 1);
      drain("up1");

      // Two detents down; start during busy ignored; restart in the done cycle.
      start_seq(1'b0, 2, 0, t);
      wait_cyc(t + 6);
      start = 1'b1; dir = 1'b1; steps = SW'(5);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t + 36);
      start_seq(1'b1, 1, 0, t);
      drain("down2_restart");

      // Zero detents: immediate done, no busy.
      start_seq(1'b1, 0, 0, t);
      drain("zero");

      // Abort mid-detent drops the remaining detents.
      start_seq(1'b1, 3, 9, t);
      wait_cyc(t + 9);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      drain("abort");

      // Abort together with start in IDLE: start wins, full sequence.
      abort = 1'b1;
      start_seq(1'b0, 1, 0, t);
      abort = 1'b0;
      drain("abort_start");

      // Abort during TAIL has no effect.
      start_seq(1'b1, 2, 0, t);
      wait_cyc(t + 33);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      drain("abort_tail");

      // Asynchronous reset mid-run: outputs clear at once, no done afterwards.
      start_seq(1'b1, 2, 0, t);
      wait_cyc(t + 10);
      mon_en = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("midrst_a", a, 0);
      chk("midrst_b", b, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_steps_left", steps_left, 0);
      chk("midrst_done", done, 0);
      sbq.delete();
      model_sl = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (40) @(negedge clk);

      // Clean restart after reset.
      start_seq(1'b0, 1, 0, t);
      drain("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
